// File: rtl/r2mdc_commutator_pkg.sv
// Shared FFT-pipeline definitions used by the R2MDC delay-commutator stage:
// the Q7.8 sample width, a complex sample type, the switch-mode encoding and
// the log2 helper that sizes the sample counter and ring-buffer pointers.
package r2mdc_commutator_pkg;

    // Width of one real or imaginary component in signed Q7.8.
    localparam int Q78_WIDTH = 16;

    // Delay lines up to this depth are built as plain shift registers;
    // deeper lines switch to a circular buffer so that only one entry
    // moves per accepted sample.
    localparam int SHIFT_MAX_DEPTH = 8;

    // One complex sample, real part in the upper half.
    typedef struct packed {
        logic signed [Q78_WIDTH-1:0] re;
        logic signed [Q78_WIDTH-1:0] im;
    } cplx_t;

    // Commutator switch position. STRAIGHT routes the upper stream to the
    // upper path; CROSS swaps the upper stream with the delayed lower one.
    typedef enum logic {
        SW_STRAIGHT = 1'b0,
        SW_CROSS    = 1'b1
    } sw_mode_e;

    // Ceiling log2 of a delay depth. DELAY is a power of two, so this is
    // the exact exponent; depth 1 yields 0.
    function automatic int delay_log2(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/r2mdc_commutator_delay_line.sv
// Enable-gated fixed-depth delay line. The output is the word that was
// written DEPTH enabled cycles earlier, presented combinationally so the
// caller can register it in the same cycle that a new word is written.
module r2mdc_commutator_delay_line
    import r2mdc_commutator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH <= SHIFT_MAX_DEPTH) begin : g_shift

            logic [WIDTH-1:0] taps [DEPTH];

            // Shift one position per enabled cycle; the last tap is the output.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        taps[i] <= '0;
                    end
                end else if (en) begin
                    // NOTE: non-blocking updates make every tap read its
                    // neighbour's old value, so the loop order is irrelevant.
                    taps[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        taps[i] <= taps[i-1];
                    end
                end
            end

            assign q = taps[DEPTH-1];

        end else begin : g_ring

            localparam int PTR_W = delay_log2(DEPTH);

            logic [WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0] ptr;

            // Pointer walks the ring; DEPTH is a power of two so it wraps
            // naturally at the top of its range.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ptr <= '0;
                end else if (en) begin
                    ptr <= ptr + PTR_W'(1);
                end
            end

            // Overwrite the oldest entry, which is read out in the same cycle.
            // NOTE: the storage array has no reset; stale words are masked by
            // the stage's primed flag and a reset here would stop the array
            // mapping onto RAM.
            always_ff @(posedge clk) begin
                if (en) begin
                    mem[ptr] <= d;
                end
            end

            assign q = mem[ptr];

        end
    endgenerate

endmodule

// File: rtl/r2mdc_commutator.sv
// R2MDC delay-commutator stage. Reorders two parallel complex streams through
// two DELAY-deep delay lines and a periodic switch so that each output pair
// (A, B) holds samples DELAY positions apart from the same input stream,
// ready for the radix-2 butterfly that follows. Data passes bit-exact.
module r2mdc_commutator
    import r2mdc_commutator_pkg::*;
#(
    parameter int DELAY = 4,
    parameter int WIDTH = Q78_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in0_re,
    input  logic [WIDTH-1:0] in0_im,
    input  logic [WIDTH-1:0] in1_re,
    input  logic [WIDTH-1:0] in1_im,
    output logic             out_valid,
    output logic [WIDTH-1:0] A_re,
    output logic [WIDTH-1:0] A_im,
    output logic [WIDTH-1:0] B_re,
    output logic [WIDTH-1:0] B_im
);

    localparam int LOG2D  = delay_log2(DELAY);
    localparam int CNT_W  = LOG2D + 1;
    localparam int PAIR_W = 2 * WIDTH;

    // Counter value of the last sample before the outputs become meaningful.
    localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(DELAY - 1);

    // Accepted-sample counter modulo 2*DELAY; its top bit is the switch.
    logic [CNT_W-1:0]  cnt;
    logic              primed;
    sw_mode_e          sw;

    // Complex samples carried as {re, im} words through the datapath.
    logic [PAIR_W-1:0] in0_w;
    logic [PAIR_W-1:0] in1_w;
    logic [PAIR_W-1:0] bd;      // lower stream delayed DELAY samples
    logic [PAIR_W-1:0] upper;   // post-switch upper path
    logic [PAIR_W-1:0] lower;   // post-switch lower path, goes straight to B
    logic [PAIR_W-1:0] a_del;   // upper path delayed DELAY samples
    logic [PAIR_W-1:0] a_q;
    logic [PAIR_W-1:0] b_q;

    assign in0_w = {in0_re, in0_im};
    assign in1_w = {in1_re, in1_im};

    // Lower input stream delay (bd).
    r2mdc_commutator_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (PAIR_W)
    ) u_dl_lower (
        .clk   (clk),
        .reset (reset),
        .en    (in_valid),
        .d     (in1_w),
        .q     (bd)
    );

    // Switch: straight half-period keeps in0 on top, cross half-period swaps
    // the current upper sample with the delayed lower one.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // which is what keeps it purely combinational with no latches.
        sw    = sw_mode_e'(cnt[LOG2D]);
        upper = in0_w;
        lower = bd;
        if (sw == SW_CROSS) begin
            upper = bd;
            lower = in0_w;
        end
    end

    // Upper path delay after the switch; its output becomes A.
    r2mdc_commutator_delay_line #(
        .DEPTH (DELAY),
        .WIDTH (PAIR_W)
    ) u_dl_upper (
        .clk   (clk),
        .reset (reset),
        .en    (in_valid),
        .d     (upper),
        .q     (a_del)
    );

    // Sample counter and sticky primed flag; both advance only on accepted
    // samples, and reset wins over a simultaneous in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (in_valid) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == PRIME_CNT) begin
                primed <= 1'b1;
            end
        end
    end

    // Output registers: capture a pair for every accepted sample once the
    // delay lines hold only real data; otherwise hold the last pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            out_valid <= in_valid && primed;
            if (in_valid && primed) begin
                a_q <= a_del;
                b_q <= lower;
            end
        end
    end

    assign A_re = a_q[PAIR_W-1 -: WIDTH];
    assign A_im = a_q[WIDTH-1:0];
    assign B_re = b_q[PAIR_W-1 -: WIDTH];
    assign B_im = b_q[WIDTH-1:0];

endmodule

// File: tb/tb_r2mdc_commutator.sv
// Scoreboard bench for r2mdc_commutator with DELAY = 2, 1 and 8 side by side.
// Stimulus pushes the pair the pairing rules predict; a negedge monitor pops
// and compares whenever a DUT presents out_valid, and checks that A/B hold
// their previous value otherwise.
module tb_r2mdc_commutator;
    import r2mdc_commutator_pkg::*;

    typedef struct packed {
        cplx_t a;
        cplx_t b;
    } pair_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  iv = '0;
    cplx_t       in0 = '0;
    cplx_t       in1 = '0;

    logic [15:0] ar [3];
    logic [15:0] ai [3];
    logic [15:0] br [3];
    logic [15:0] bi [3];
    logic        ov [3];

    int checks = 0;
    int errors = 0;

    pair_t q0[$];
    pair_t q1[$];
    pair_t q2[$];
    pair_t last  [3];
    int    n_acc [3];
    cplx_t ha [3][0:127];
    cplx_t hb [3][0:127];

    always #5 clk = ~clk;

    r2mdc_commutator #(.DELAY(2), .WIDTH(16)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(iv[0]),
        .in0_re(in0.re), .in0_im(in0.im), .in1_re(in1.re), .in1_im(in1.im),
        .out_valid(ov[0]), .A_re(ar[0]), .A_im(ai[0]), .B_re(br[0]), .B_im(bi[0]));

    r2mdc_commutator #(.DELAY(1), .WIDTH(16)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]),
        .in0_re(in0.re), .in0_im(in0.im), .in1_re(in1.re), .in1_im(in1.im),
        .out_valid(ov[1]), .A_re(ar[1]), .A_im(ai[1]), .B_re(br[1]), .B_im(bi[1]));

    r2mdc_commutator #(.DELAY(8), .WIDTH(16)) u_d8 (
        .clk(clk), .reset(reset), .in_valid(iv[2]),
        .in0_re(in0.re), .in0_im(in0.im), .in1_re(in1.re), .in1_im(in1.im),
        .out_valid(ov[2]), .A_re(ar[2]), .A_im(ai[2]), .B_re(br[2]), .B_im(bi[2]));

    function automatic int dly_of(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 8;
    endfunction

    function automatic cplx_t a_of(int n);
        cplx_t c;
        c.re = 16'(n);
        c.im = 16'(-n);
        return c;
    endfunction

    function automatic cplx_t b_of(int n);
        cplx_t c;
        c.re = 16'(100 + n);
        c.im = 16'(-100 - n);
        return c;
    endfunction

    function automatic logic [15:0] rnd_word();
        int pick;
        pick = $urandom_range(0, 3);
        if (pick == 0) return 16'h7FFF;
        if (pick == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    function automatic cplx_t rnd_c();
        cplx_t c;
        c.re = rnd_word();
        c.im = rnd_word();
        return c;
    endfunction

    function automatic pair_t got_of(int k);
        return {ar[k], ai[k], br[k], bi[k]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: sample n of a stream pairs with sample n-D of the same
    // stream. Odd half-periods pair the upper stream (a(n-D), a(n)); even
    // half-periods pair the lower stream (b(n-2D), b(n-D)). No output for n<D.
    task automatic issue(int k, cplx_t a, cplx_t b);
        int    n;
        int    d;
        pair_t e;
        n = n_acc[k];
        d = dly_of(k);
        ha[k][n] = a;
        hb[k][n] = b;
        if (n >= d) begin
            if (((n / d) % 2) == 1) begin
                e.a = ha[k][n-d];
                e.b = a;
            end else begin
                e.a = hb[k][n-2*d];
                e.b = hb[k][n-d];
            end
            case (k)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
        n_acc[k] = n + 1;
    endtask

    task automatic send(int k, cplx_t a, cplx_t b, logic v);
        @(posedge clk);
        #1;
        in0 = a;
        in1 = b;
        iv = '0;
        iv[k] = v;
        if (v) issue(k, a, b);
    endtask

    task automatic idle(int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            iv = '0;
            in0 = rnd_c();
            in1 = rnd_c();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        iv = '0;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) begin
            last[k] = '0;
            n_acc[k] = 0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_out_valid_dut%0d", k), 64'(ov[k]), 64'd0);
            check($sformatf("reset_pair_dut%0d", k), got_of(k), 64'd0);
        end
    endtask

    task automatic mon(int k);
        pair_t e;
        logic  have;
        have = 1'b0;
        e = '0;
        if (ov[k] === 1'b1) begin
            case (k)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair_dut%0d got=%h required=no output", k, got_of(k));
            end else begin
                check($sformatf("pair_dut%0d", k), got_of(k), e);
                last[k] = e;
            end
        end else begin
            check($sformatf("hold_dut%0d", k), got_of(k), last[k]);
        end
    endtask

    // Monitor: runs on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                mon(k);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            last[k] = '0;
            n_acc[k] = 0;
        end

        // DELAY=2, continuous stream n=0..7.
        do_reset();
        for (int n = 0; n < 8; n++) send(0, a_of(n), b_of(n), 1'b1);
        idle(3);

        // DELAY=2 with a three-cycle gap after n=3.
        do_reset();
        for (int n = 0; n < 4; n++) send(0, a_of(n), b_of(n), 1'b1);
        idle(3);
        for (int n = 4; n < 8; n++) send(0, a_of(n), b_of(n), 1'b1);
        idle(3);

        // DELAY=2, reset mid-stream after n=4, then restart at n=0.
        do_reset();
        for (int n = 0; n < 5; n++) send(0, a_of(n), b_of(n), 1'b1);
        do_reset();
        for (int n = 0; n < 8; n++) send(0, a_of(n), b_of(n), 1'b1);
        idle(3);

        // DELAY=1, n=0..5.
        do_reset();
        for (int n = 0; n < 6; n++) send(1, a_of(n), b_of(n), 1'b1);
        idle(3);

        // DELAY=8, 64 continuous samples across several counter wraps.
        do_reset();
        for (int n = 0; n < 64; n++) send(2, a_of(n), b_of(n), 1'b1);
        idle(3);

        // Random data including full-scale extremes, random in_valid gaps.
        for (int k = 0; k < 3; k++) begin
            do_reset();
            while (n_acc[k] < 100) begin
                send(k, rnd_c(), rnd_c(), $urandom_range(0, 3) != 0);
            end
            idle(3);
        end

        idle(4);
        check("drain_dut0", 64'(q0.size()), 64'd0);
        check("drain_dut1", 64'(q1.size()), 64'd0);
        check("drain_dut2", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
